// File: rtl/overlay_mac_sequencer.sv
// overlay_mac_sequencer
// Job-level controller for the C3x2/F2 27x18 MAC overlay. Takes a dot-product
// job, streams operand beats into the overlay, closes the accumulation loop
// through ovl_result_2, and returns the final 45-bit sum plus SIMD carry.
// Optional feature: define OVL_SEQ_BIAS_EN to add a start_bias input that
// seeds the accumulation (and is the result of a zero-length job).
module overlay_mac_sequencer #(
   parameter int LEN_W   = 16,
   parameter int OVL_LAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [LEN_W-1:0] start_len,
   input  logic [1:0]       start_mode,
   input  logic             start_a_sign,
   input  logic             start_b_sign,
`ifdef OVL_SEQ_BIAS_EN
   input  logic [44:0]      start_bias,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [53:0]      in_a,
   input  logic [53:0]      in_b,
   output logic [1:0]       ovl_mode,
   output logic [53:0]      ovl_a,
   output logic [53:0]      ovl_b,
   output logic             ovl_a_sign,
   output logic             ovl_b_sign,
   output logic [44:0]      ovl_result_2,
   output logic             ovl_cin,
   input  logic [44:0]      ovl_s,
   input  logic [15:0]      ovl_carry,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [44:0]      res_sum,
   output logic [15:0]      res_carry,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Tag pipe length: its tail lines up with the overlay ALU stage.
   localparam int TAG_STAGES = OVL_LAT - 1;

   // Tag bit positions: {vld, first, last}
   localparam int TAG_VLD   = 2;
   localparam int TAG_FIRST = 1;
   localparam int TAG_LAST  = 0;

   state_t                     state;
   state_t                     state_next;
   logic   [LEN_W-1:0]         cnt;
   logic                       first_pending;
   logic   [TAG_STAGES-1:0][2:0] tag_pipe;
   logic   [2:0]               tag_tail;
   logic                       drain_cap;
   logic   [44:0]              first_feedback;
   logic                       start_fire;
   logic                       beat_fire;
   logic                       last_beat;
   logic                       len_zero;

   assign start_fire = start_valid & start_ready;
   assign beat_fire  = in_valid & in_ready;
   assign last_beat  = beat_fire && (cnt == LEN_W'(1));
   assign len_zero   = (start_len == '0);
   assign tag_tail   = tag_pipe[TAG_STAGES-1];
   assign ovl_cin    = 1'b0;

`ifdef OVL_SEQ_BIAS_EN
   logic [44:0] bias_q;

   // Hold the job's bias so the first beat (or an empty job) can use it.
   always_ff @(posedge clk) begin
      if (reset) begin
         bias_q <= '0;
      end else if (start_fire) begin
         bias_q <= start_bias;
      end
   end

   assign first_feedback = bias_q;
`else
   assign first_feedback = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: an empty job skips straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_fire) state_next = len_zero ? DONE : RUN;
         RUN:     if (last_beat) state_next = DRAIN;
         DRAIN:   if (drain_cap) state_next = DONE;
         DONE:    if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      start_ready = 1'b0;
      in_ready    = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
         end
         RUN:     in_ready  = 1'b1;
         DONE:    res_valid = 1'b1;
         default: ;
      endcase
   end

   // Job bookkeeping: overlay mode/signs stay fixed for the whole job; an
   // empty job leaves the overlay configuration untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt           <= '0;
         first_pending <= 1'b0;
         ovl_mode      <= '0;
         ovl_a_sign    <= 1'b0;
         ovl_b_sign    <= 1'b0;
      end else if (start_fire) begin
         cnt           <= start_len;
         first_pending <= 1'b1;
         if (!len_zero) begin
            ovl_mode   <= start_mode;
            ovl_a_sign <= start_a_sign;
            ovl_b_sign <= start_b_sign;
         end
      end else if (beat_fire) begin
         cnt           <= cnt - LEN_W'(1);
         first_pending <= 1'b0;
      end
   end

   // Operand drive: bubbles push zeros so the overlay adds a zero product.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovl_a <= '0;
         ovl_b <= '0;
      end else if (beat_fire) begin
         ovl_a <= in_a;
         ovl_b <= in_b;
      end else begin
         ovl_a <= '0;
         ovl_b <= '0;
      end
   end

   // Tag pipe follows each driven cycle down to the overlay ALU stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_pipe  <= '0;
         drain_cap <= 1'b0;
      end else begin
         tag_pipe[0] <= {beat_fire, beat_fire & first_pending, last_beat};
         for (int i = 1; i < TAG_STAGES; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
         drain_cap <= tag_tail[TAG_VLD] & tag_tail[TAG_LAST];
      end
   end

   // Accumulator feedback: restart on the first beat, otherwise add onto
   // the running S_reg (bubbles included, their product being zero).
   always_comb begin
      ovl_result_2 = '0;
      if (state == RUN || state == DRAIN) begin
         if (tag_tail[TAG_VLD] && tag_tail[TAG_FIRST]) begin
            ovl_result_2 = first_feedback;
         end else begin
            ovl_result_2 = ovl_s;
         end
      end
   end

   // Result capture: once the last beat has landed in S_reg, or at the
   // start of an empty job; held until the result handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_sum   <= '0;
         res_carry <= '0;
      end else if (start_fire && len_zero) begin
         res_sum   <= first_feedback_start();
         res_carry <= '0;
      end else if (state == DRAIN && drain_cap) begin
         res_sum   <= ovl_s;
         res_carry <= ovl_carry;
      end
   end

   // Value an empty job returns: the incoming bias (if enabled) or zero.
   function automatic logic [44:0] first_feedback_start();
`ifdef OVL_SEQ_BIAS_EN
      return start_bias;
`else
      return 45'd0;
`endif
   endfunction

endmodule

// File: tb/tb_overlay_mac_sequencer.sv
// tb_overlay_mac_sequencer
// Table-driven bench for overlay_mac_sequencer with a behavioural model of
// the overlay (lane-0 27x18 product, OVL_LAT=3) closing the feedback loop.
// Honours OVL_SEQ_BIAS_EN when defined.
module tb_overlay_mac_sequencer;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] start_len;
   logic [1:0]  start_mode;
   logic        start_a_sign;
   logic        start_b_sign;
   logic [44:0] start_bias;
   logic        in_valid;
   logic        in_ready;
   logic [53:0] in_a;
   logic [53:0] in_b;
   logic [1:0]  ovl_mode;
   logic [53:0] ovl_a;
   logic [53:0] ovl_b;
   logic        ovl_a_sign;
   logic        ovl_b_sign;
   logic [44:0] ovl_result_2;
   logic        ovl_cin;
   logic [44:0] ovl_s;
   logic [15:0] ovl_carry;
   logic        res_valid;
   logic        res_ready;
   logic [44:0] res_sum;
   logic [15:0] res_carry;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   overlay_mac_sequencer #(.LEN_W(16), .OVL_LAT(LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .start_len    (start_len),
      .start_mode   (start_mode),
      .start_a_sign (start_a_sign),
      .start_b_sign (start_b_sign),
`ifdef OVL_SEQ_BIAS_EN
      .start_bias   (start_bias),
`endif
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .ovl_mode     (ovl_mode),
      .ovl_a        (ovl_a),
      .ovl_b        (ovl_b),
      .ovl_a_sign   (ovl_a_sign),
      .ovl_b_sign   (ovl_b_sign),
      .ovl_result_2 (ovl_result_2),
      .ovl_cin      (ovl_cin),
      .ovl_s        (ovl_s),
      .ovl_carry    (ovl_carry),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_sum      (res_sum),
      .res_carry    (res_carry),
      .busy         (busy)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Overlay model: 27x18 lane-0 product (sign per a/b sign bit), one
   // product stage, then the ALU adds result_2 into S_reg.
   function automatic logic [44:0] lane0Product(input logic [53:0] a, input logic [53:0] b,
                                                input logic aSign, input logic bSign);
      logic signed [45:0] ax;
      logic signed [45:0] bx;
      logic signed [45:0] p;
      ax = aSign ? {{19{a[26]}}, a[26:0]} : {19'b0, a[26:0]};
      bx = bSign ? {{28{b[17]}}, b[17:0]} : {28'b0, b[17:0]};
      p  = ax * bx;
      return p[44:0];
   endfunction

   logic [44:0] modelProd;
   logic [44:0] modelSum;
   logic [44:0] sumNext;

   assign sumNext   = modelProd + ovl_result_2;
   assign ovl_s     = modelSum;

   // Overlay pipeline registers, cleared by the shared reset.
   always @(posedge clk) begin
      if (reset) begin
         modelProd <= '0;
         modelSum  <= '0;
         ovl_carry <= '0;
      end else begin
         modelProd <= lane0Product(ovl_a, ovl_b, ovl_a_sign, ovl_b_sign);
         modelSum  <= sumNext;
         ovl_carry <= sumNext[44:29];
      end
   end

   typedef struct {
      int               len;
      logic [1:0]       mode;
      logic             aSign;
      logic             bSign;
      logic [3:0][53:0] a;
      logic [3:0][53:0] b;
      int               gap;
      int               hold;
      logic [44:0]      expSum;
      logic [15:0]      expCarry;
   } jobVec_t;

   jobVec_t vecs[9];

   function automatic jobVec_t mkVec(input int len, input logic [1:0] mode,
                                     input logic aSign, input logic bSign,
                                     input logic [53:0] a0, input logic [53:0] a1,
                                     input logic [53:0] a2, input logic [53:0] a3,
                                     input logic [53:0] b0, input logic [53:0] b1,
                                     input logic [53:0] b2, input logic [53:0] b3,
                                     input int gap, input int hold,
                                     input logic [44:0] expSum, input logic [15:0] expCarry);
      jobVec_t v;
      v.len = len; v.mode = mode; v.aSign = aSign; v.bSign = bSign;
      v.a = {a3, a2, a1, a0};
      v.b = {b3, b2, b1, b0};
      v.gap = gap; v.hold = hold; v.expSum = expSum; v.expCarry = expCarry;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Run one table job: start, stream beats (with gaps), collect the result.
   task automatic applyStimulus(input int idx);
      jobVec_t     v;
      int          lastCyc;
      int          waitCnt;
      logic [44:0] heldSum;
      v = vecs[idx];
      lastCyc = cyc;
      @(negedge clk);
      start_valid  = 1'b1;
      start_len    = v.len[15:0];
      start_mode   = v.mode;
      start_a_sign = v.aSign;
      start_b_sign = v.bSign;
      start_bias   = '0;
      checkOutput($sformatf("v%0d_start_ready", idx), {63'b0, start_ready}, 64'd1);
      @(negedge clk);
      start_valid = 1'b0;
      for (int k = 0; k < v.len; k++) begin
         in_valid = 1'b1;
         in_a     = v.a[k];
         in_b     = v.b[k];
         waitCnt  = 0;
         while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
         end
         if (!in_ready) checkOutput($sformatf("v%0d_in_ready_timeout", idx), 64'd0, 64'd1);
         if (k == 0) begin
            checkOutput($sformatf("v%0d_ovl_mode", idx), {62'b0, ovl_mode}, {62'b0, v.mode});
            checkOutput($sformatf("v%0d_ovl_signs", idx), {62'b0, ovl_a_sign, ovl_b_sign},
                        {62'b0, v.aSign, v.bSign});
         end
         lastCyc = cyc;
         @(negedge clk);
         in_valid = 1'b0;
         in_a     = 54'h2A_5A5A_5A5A_5A5A;
         in_b     = 54'h15_A5A5_A5A5_A5A5;
         if (k < v.len - 1) begin
            for (int g = 0; g < v.gap; g++) begin
               if (g == 1) begin
                  checkOutput($sformatf("v%0d_bubble_ovl_a", idx), {10'b0, ovl_a}, 64'd0);
                  checkOutput($sformatf("v%0d_bubble_ovl_b", idx), {10'b0, ovl_b}, 64'd0);
               end
               @(negedge clk);
            end
         end
      end
      checkOutput($sformatf("v%0d_in_ready_after_last", idx), {63'b0, in_ready}, 64'd0);
      waitCnt = 0;
      while (!res_valid && waitCnt < 30) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput($sformatf("v%0d_res_latency", idx), 64'(cyc - lastCyc), 64'(LAT + 1));
      checkOutput($sformatf("v%0d_res_sum", idx), {19'b0, res_sum}, {19'b0, v.expSum});
      checkOutput($sformatf("v%0d_res_carry", idx), {48'b0, res_carry}, {48'b0, v.expCarry});
      heldSum = v.expSum;
      for (int h = 0; h < v.hold; h++) begin
         checkOutput($sformatf("v%0d_hold_sum_%0d", idx, h), {19'b0, res_sum}, {19'b0, heldSum});
         checkOutput($sformatf("v%0d_hold_start_ready_%0d", idx, h), {63'b0, start_ready}, 64'd0);
         start_valid = (h == 3);
         start_len   = 16'd5;
         @(negedge clk);
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput($sformatf("v%0d_idle_busy", idx), {63'b0, busy}, 64'd0);
      checkOutput($sformatf("v%0d_idle_start_ready", idx), {63'b0, start_ready}, 64'd1);
   endtask

   // Watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, table jobs, then the hand-written corner cases.
   initial begin
      logic [44:0] len0Exp;

      vecs[0] = mkVec(3, 2'b00, 0, 0, 2, 3, 4, 0, 5, 6, 7, 0, 0, 0, 45'd56, 16'h0);
      vecs[1] = mkVec(3, 2'b00, 0, 0, 2, 3, 4, 0, 5, 6, 7, 0, 2, 0, 45'd56, 16'h0);
      vecs[2] = mkVec(2, 2'b00, 1, 1, -54'sd3, 1, 0, 0, 4, -54'sd2, 0, 0, 0, 0,
                      45'h1FFF_FFFF_FFF2, 16'hFFFF);
      vecs[3] = mkVec(2, 2'b00, 1, 1, -54'sd3, 1, 0, 0, 4, -54'sd2, 0, 0, 1, 0,
                      45'h1FFF_FFFF_FFF2, 16'hFFFF);
      vecs[4] = mkVec(4, 2'b10, 0, 0, 1, 1, 1, 1, 100, 200, 300, 400, 0, 0, 45'd1000, 16'h0);
      vecs[5] = mkVec(1, 2'b00, 1, 0, -54'sd5, 0, 0, 0, 3, 0, 0, 0, 0, 0,
                      45'h1FFF_FFFF_FFF1, 16'hFFFF);
      vecs[6] = mkVec(1, 2'b01, 0, 0, 54'h7FF_FFFF, 0, 0, 0, 54'h3_FFFF, 0, 0, 0, 0, 0,
                      45'h1FFF_F7FC_0001, 16'hFFFF);
      vecs[7] = mkVec(1, 2'b00, 0, 0, 7, 0, 0, 0, 8, 0, 0, 0, 0, 10, 45'd56, 16'h0);
      vecs[8] = mkVec(1, 2'b00, 0, 0, 7, 0, 0, 0, 8, 0, 0, 0, 0, 0, 45'd56, 16'h0);

      reset        = 1'b1;
      start_valid  = 1'b0;
      start_len    = '0;
      start_mode   = '0;
      start_a_sign = 1'b0;
      start_b_sign = 1'b0;
      start_bias   = '0;
      in_valid     = 1'b0;
      in_a         = '0;
      in_b         = '0;
      res_ready    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_start_ready", {63'b0, start_ready}, 64'd1);
      checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd0);
      checkOutput("rst_res_valid", {63'b0, res_valid}, 64'd0);
      checkOutput("rst_res_sum", {19'b0, res_sum}, 64'd0);
      checkOutput("rst_busy", {63'b0, busy}, 64'd0);
      checkOutput("rst_result_2", {19'b0, ovl_result_2}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) applyStimulus(i);

      // Empty job: result straight away, overlay left as the previous job set it.
`ifdef OVL_SEQ_BIAS_EN
      len0Exp = 45'd9;
`else
      len0Exp = 45'd0;
`endif
      @(negedge clk);
      start_valid  = 1'b1;
      start_len    = 16'd0;
      start_mode   = 2'b11;
      start_a_sign = 1'b1;
      start_b_sign = 1'b1;
      start_bias   = 45'd9;
      @(negedge clk);
      start_valid = 1'b0;
      start_bias  = '0;
      checkOutput("len0_res_valid", {63'b0, res_valid}, 64'd1);
      checkOutput("len0_res_sum", {19'b0, res_sum}, {19'b0, len0Exp});
      checkOutput("len0_res_carry", {48'b0, res_carry}, 64'd0);
      checkOutput("len0_ovl_mode", {62'b0, ovl_mode}, 64'd1);
      checkOutput("len0_ovl_a_sign", {63'b0, ovl_a_sign}, 64'd0);
      checkOutput("len0_ovl_a", {10'b0, ovl_a}, 64'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("len0_idle_busy", {63'b0, busy}, 64'd0);

      // Result held while res_ready stays low; a start pulse there is dropped.
      applyStimulus(7);
      @(negedge clk);
      checkOutput("hold_start_ignored_busy", {63'b0, busy}, 64'd0);

      // Reset in the middle of a five-beat job, then a fresh job.
      start_valid  = 1'b1;
      start_len    = 16'd5;
      start_mode   = 2'b00;
      start_a_sign = 1'b0;
      start_b_sign = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_a     = 54'(k + 3);
         in_b     = 54'(k + 9);
         @(negedge clk);
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
      checkOutput("midrst_in_ready", {63'b0, in_ready}, 64'd0);
      checkOutput("midrst_res_valid", {63'b0, res_valid}, 64'd0);
      checkOutput("midrst_start_ready", {63'b0, start_ready}, 64'd1);
      checkOutput("midrst_ovl_a", {10'b0, ovl_a}, 64'd0);
      applyStimulus(8);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
